// File: rtl/qam_pkg.sv
// Shared types and helpers for the QAM mapper: constellation modes, FSM states,
// bits-per-axis lookup and Gray-to-binary conversion.
package qam_pkg;

    localparam int SYM_W = 6;

    typedef enum logic [1:0] {
        QPSK  = 2'd0,
        QAM16 = 2'd1,
        QAM64 = 2'd2
    } qam_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } qam_state_e;

    function automatic logic [1:0] bits_per_axis(input qam_mode_e m);
        case (m)
            QPSK:    return 2'd1;
            QAM64:   return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    // Narrower Gray codes sit zero-extended in the low bits, which converts correctly.
    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/qam_sym_fifo.sv
// Symbol FIFO for the QAM mapper: registered storage, wrap-bit pointers,
// full/empty flags. Simultaneous push and pop keep the occupancy unchanged.
module qam_sym_fifo
    import qam_pkg::*;
#(
    parameter int WIDTH = SYM_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/qam_mapper_multi.sv
// Multi-mode QAM mapper (QPSK/16-QAM/64-QAM) with input FIFO, stallable output
// register and frame FSM. Define QAM_DROP_CNT_EN to add the drop_cnt output.
module qam_mapper_multi
    import qam_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       symbol,
    input  logic [1:0]       mode,
    input  logic             data_valid_i,
    input  logic             start,
    input  logic             done_flag_i,
    input  logic             out_ready_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] I_data,
    output logic [OUT_W-1:0] Q_data,
    output logic             data_valid_o,
    output logic             done_flag_o,
`ifdef QAM_DROP_CNT_EN
    output logic [15:0]      drop_cnt,
`endif
    output qam_state_e       state_o
);

    // Valid/ready: a symbol moves on a cycle where its valid and the receiver's
    // ready are both high; a stalled output keeps data and valid stable.

    qam_state_e       state_q, state_d;
    qam_mode_e        mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] i_q, i_d, q_q, q_d;

    logic             push, pop, fifo_full, fifo_empty;
    logic [5:0]       fifo_dout;
    logic [1:0]       b;
    logic [2:0]       mask, g_i, g_q;

    function automatic logic [OUT_W-1:0] map_axis(input logic [2:0] g, input logic [1:0] nb);
        int lvl;
        lvl = 2 * int'(gray2bin(g)) - ((1 << nb) - 1);
        return OUT_W'(lvl * (1 << (OUT_W - 1 - int'(nb))));
    endfunction

    qam_sym_fifo #(.WIDTH(SYM_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (symbol),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ready_o     = (state_q == RUN) && !fifo_full;
        push        = data_valid_i && ready_o;
        pop         = !fifo_empty && (!out_valid_q || out_ready_i);
        done_flag_o = (state_q == DRAIN) && fifo_empty && !out_valid_q;

        b    = bits_per_axis(mode_q);
        mask = 3'((1 << b) - 1);
        g_i  = 3'(fifo_dout >> b) & mask;
        g_q  = fifo_dout[2:0] & mask;

        state_d     = state_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        i_d         = i_q;
        q_d         = q_q;

        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                mode_d  = (mode == 2'd3) ? QAM16 : qam_mode_e'(mode);
            end
            RUN:     if (done_flag_i) state_d = DRAIN;
            DRAIN:   if (done_flag_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            i_d         = map_axis(g_i, b);
            q_d         = map_axis(g_q, b);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= QAM16;
            out_valid_q <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            i_q         <= i_d;
            q_q         <= q_d;
        end
    end

    assign I_data       = i_q;
    assign Q_data       = q_q;
    assign data_valid_o = out_valid_q;
    assign state_o      = state_q;

`ifdef QAM_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == IDLE && start) begin
            drop_cnt_d = '0;
        end else if (state_q == RUN && data_valid_i && !ready_o && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_qam_mapper_multi.sv
// Self-checking bench for qam_mapper_multi: vector table, scoreboard queue and
// hand-written sequences for latency, backpressure, empty frames and mid-frame reset.
module tb_qam_mapper_multi;
    import qam_pkg::*;

    localparam int OUT_W = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       symbol = '0;
    logic [1:0]       mode = '0;
    logic             data_valid_i = 1'b0;
    logic             start = 1'b0;
    logic             done_flag_i = 1'b0;
    logic             out_ready_i;
    logic             ready_o;
    logic [OUT_W-1:0] I_data, Q_data;
    logic             data_valid_o;
    logic             done_flag_o;
    qam_state_e       state_o;
`ifdef QAM_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    logic ready_man = 1'b1;
    logic rnd_en    = 1'b0;
    logic rnd_bit   = 1'b1;
    assign out_ready_i = rnd_en ? rnd_bit : ready_man;

    int checks   = 0;
    int errors   = 0;
    int out_cnt  = 0;
    int done_cnt = 0;
    logic done_prev = 1'b0;
    logic [1:0] cur_mode = 2'd1;
    logic [2*OUT_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0] mode;
        logic [5:0] sym;
        logic [7:0] ei;
        logic [7:0] eq;
        string      name;
    } vec_t;
    vec_t vecs[7];

    qam_mapper_multi #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .symbol       (symbol),
        .mode         (mode),
        .data_valid_i (data_valid_i),
        .start        (start),
        .done_flag_i  (done_flag_i),
        .out_ready_i  (out_ready_i),
        .ready_o      (ready_o),
        .I_data       (I_data),
        .Q_data       (Q_data),
        .data_valid_o (data_valid_o),
        .done_flag_o  (done_flag_o),
`ifdef QAM_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Reference mapping by searching the Gray code of each index.
    function automatic logic [7:0] model_axis(input int b, input int g);
        int lvl = 0;
        for (int n = 0; n < (1 << b); n++) begin
            if ((n ^ (n >> 1)) == g) lvl = 2 * n - ((1 << b) - 1);
        end
        return 8'(lvl * (1 << (OUT_W - 1 - b)));
    endfunction

    function automatic logic [15:0] model_iq(input logic [1:0] m, input logic [5:0] s);
        int b;
        b = (m == 2'd0) ? 1 : (m == 2'd2) ? 3 : 2;
        return {model_axis(b, (int'(s) >> b) & ((1 << b) - 1)), model_axis(b, int'(s) & ((1 << b) - 1))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every presented sample (held or consumed) must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with empty expected queue", {I_data, Q_data});
                end else begin
                    check("sample_iq", 32'({I_data, Q_data}), 32'(exp_q[0]));
                    if (out_ready_i) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end
            if (done_flag_o) begin
                done_cnt++;
                if (done_prev) begin
                    checks++;
                    errors++;
                    $display("FAIL done_width: done_flag_o high two cycles, required one");
                end
            end
            done_prev = done_flag_o;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic do_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cur_mode = (m == 2'd3) ? 2'd1 : m;
        check("start_run", 32'(state_o), 32'(RUN));
    endtask

    task automatic send_sym(input logic [5:0] s, input logic [15:0] e, input logic last);
        int g = 0;
        symbol       = s;
        data_valid_i = 1'b1;
        while (!ready_o && g < 200) begin
            tick();
            g++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_o stayed 0, required 1");
            data_valid_i = 1'b0;
            return;
        end
        done_flag_i = last;
        exp_q.push_back(e);
        tick();
        data_valid_i = 1'b0;
        done_flag_i  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!done_flag_o && c < 300) begin
            tick();
            c++;
        end
        if (!done_flag_o) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: done_flag_o 0, required 1", tag);
        end else begin
            check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
            tick();
            check({tag, "_done_1cyc"}, 32'(done_flag_o), 32'd0);
            check({tag, "_idle"}, 32'(state_o), 32'(IDLE));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, d0, len;
        logic [5:0] s;

        vecs[0] = '{2'd1, 6'b000000, 8'hA0, 8'hA0, "q16_0000"};
        vecs[1] = '{2'd1, 6'b001011, 8'h60, 8'h20, "q16_1011"};
        vecs[2] = '{2'd0, 6'b000001, 8'hC0, 8'h40, "qpsk_01"};
        vecs[3] = '{2'd2, 6'b100000, 8'h70, 8'h90, "q64_100000"};
        vecs[4] = '{2'd2, 6'b010010, 8'hF0, 8'hF0, "q64_010010"};
        vecs[5] = '{2'd0, 6'b111110, 8'h40, 8'hC0, "qpsk_upper"};
        vecs[6] = '{2'd3, 6'b110110, 8'hE0, 8'h60, "mode3_as_q16"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_i", 32'(I_data), 32'd0);
        check("rst_q", 32'(Q_data), 32'd0);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        check("rst_done", 32'(done_flag_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Symbols offered in IDLE are discarded.
        data_valid_i = 1'b1;
        symbol       = 6'h15;
        tick();
        tick();
        data_valid_i = 1'b0;
        check("idle_ready", 32'(ready_o), 32'd0);
        check("idle_no_out", 32'(data_valid_o), 32'd0);

        // Two-cycle latency with the reset-default 16-QAM mapping.
        do_start(2'd1);
        symbol       = 6'b000000;
        data_valid_i = 1'b1;
        check("lat_ready", 32'(ready_o), 32'd1);
        exp_q.push_back(16'hA0A0);
        tick();
        data_valid_i = 1'b0;
        check("lat_t1_valid", 32'(data_valid_o), 32'd0);
        tick();
        check("lat_t2_valid", 32'(data_valid_o), 32'd1);
        check("lat_t2_iq", 32'({I_data, Q_data}), 32'h0000A0A0);
        done_flag_i = 1'b1;
        tick();
        done_flag_i = 1'b0;
        wait_done("lat");

        for (int i = 0; i < 7; i++) begin
            do_start(vecs[i].mode);
            send_sym(vecs[i].sym, {vecs[i].ei, vecs[i].eq}, 1'b1);
            wait_done(vecs[i].name);
        end

        // Three-symbol frame: three samples then one done pulse.
        o0 = out_cnt;
        d0 = done_cnt;
        do_start(2'd1);
        send_sym(6'b000101, model_iq(cur_mode, 6'b000101), 1'b0);
        send_sym(6'b001110, model_iq(cur_mode, 6'b001110), 1'b0);
        send_sym(6'b000011, model_iq(cur_mode, 6'b000011), 1'b1);
        wait_done("frame3");
        check("frame3_samples", 32'(out_cnt - o0), 32'd3);
        check("frame3_dones", 32'(done_cnt - d0), 32'd1);

        // Zero-symbol frame.
        do_start(2'd0);
        done_flag_i = 1'b1;
        tick();
        done_flag_i = 1'b0;
        check("zero_done", 32'(done_flag_o), 32'd1);
        tick();
        check("zero_done_1cyc", 32'(done_flag_o), 32'd0);
        check("zero_idle", 32'(state_o), 32'(IDLE));

        // Start during RUN must not change the latched mode.
        do_start(2'd0);
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored", 32'(state_o), 32'(RUN));
        send_sym(6'b000001, 16'hC040, 1'b0);
        send_sym(6'b111110, 16'h40C0, 1'b1);
        wait_done("restart");

        // Backpressure: 9 symbols fit (8 in FIFO + 1 in output register).
        o0 = out_cnt;
        do_start(2'd2);
        ready_man = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s            = 6'($urandom_range(0, 63));
            symbol       = s;
            data_valid_i = 1'b1;
            check("bp_ready_hi", 32'(ready_o), 32'd1);
            exp_q.push_back(model_iq(cur_mode, s));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            symbol = 6'($urandom_range(0, 63));
            check("bp_ready_lo", 32'(ready_o), 32'd0);
            tick();
        end
        data_valid_i = 1'b0;
        check("bp_held_valid", 32'(data_valid_o), 32'd1);
`ifdef QAM_DROP_CNT_EN
        check("bp_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        done_flag_i = 1'b1;
        tick();
        done_flag_i = 1'b0;
        check("bp_drain", 32'(state_o), 32'(DRAIN));
        ready_man = 1'b1;
        wait_done("bp");
        check("bp_samples", 32'(out_cnt - o0), 32'd9);

        // Reset with buffered symbols discards them without a done pulse.
        do_start(2'd1);
`ifdef QAM_DROP_CNT_EN
        check("drop_cnt_cleared", 32'(drop_cnt), 32'd0);
`endif
        ready_man = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = 6'($urandom_range(0, 63));
            send_sym(s, model_iq(cur_mode, s), 1'b0);
        end
        tick();
        check("mr_valid_before", 32'(data_valid_o), 32'd1);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("mr_i", 32'(I_data), 32'd0);
        check("mr_q", 32'(Q_data), 32'd0);
        check("mr_valid", 32'(data_valid_o), 32'd0);
        check("mr_done", 32'(done_flag_o), 32'd0);
        check("mr_ready", 32'(ready_o), 32'd0);
        check("mr_state", 32'(state_o), 32'(IDLE));
        exp_q.delete();
        tick();
        tick();
        rst       = 1'b0;
        ready_man = 1'b1;
        tick();
        tick();
        check("mr_no_done", 32'(done_cnt - d0), 32'd0);
        check("mr_idle_valid", 32'(data_valid_o), 32'd0);
        do_start(2'd2);
        send_sym(6'b100000, 16'h7090, 1'b1);
        wait_done("after_rst");

        // Random frames with random downstream stalls.
        rnd_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            do_start(2'($urandom_range(0, 3)));
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                s = 6'($urandom_range(0, 63));
                send_sym(s, model_iq(cur_mode, s), (k == len - 1) ? 1'b1 : 1'b0);
            end
            wait_done("rand");
        end
        rnd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qam_mapper_multi.md
QAM_MAPPER_MULTI -- requirements
Module: qam_mapper_multi

Interface
- REQ-001 Parameter OUT_W, default 8: I/Q sample width, two's complement; legal values 5..16.
- REQ-002 Parameter DEPTH, default 8: input symbol FIFO depth; power of two, minimum 2.
- REQ-003 clk  in  1  single clock, rising edge.
- REQ-004 rst  in  1  asynchronous, active-high reset.
- REQ-005 symbol  in  6  input bits, active bits LSB-aligned.
- REQ-006 mode  in  2  constellation select: 0=QPSK, 1=16-QAM, 2=64-QAM, 3=reserved; sampled only at start.
- REQ-007 data_valid_i  in  1  symbol qualifier.
- REQ-008 start  in  1  frame start pulse.
- REQ-009 done_flag_i  in  1  last-symbol marker for the frame.
- REQ-010 out_ready_i  in  1  downstream ready.
- REQ-011 ready_o  out  1  symbol accept enable.
- REQ-012 I_data, Q_data  out  OUT_W each  mapped in-phase and quadrature samples.
- REQ-013 data_valid_o  out  1  I/Q valid.
- REQ-014 done_flag_o  out  1  frame-complete pulse.

Function
- REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
  - IDLE->RUN on start.
  - RUN->DRAIN on accepted done_flag_i.
  - DRAIN->IDLE when the FIFO and output register are both empty.
- REQ-016 On start in IDLE, mode SHALL be latched; mode 3 SHALL be latched as 16-QAM; start outside IDLE SHALL be ignored.
- REQ-017 ready_o SHALL equal (state==RUN && FIFO not full); symbol is accepted only when data_valid_i && ready_o.
- REQ-018 data_valid_i when ready_o=0 (including IDLE and DRAIN) SHALL be discarded with no effect.
- REQ-019 done_flag_i SHALL be honoured only in RUN.
  - With data_valid_i && ready_o in the same cycle, that symbol is the last symbol of the frame.
  - Alone, it ends the frame with no added symbol.
- REQ-020 Bits per axis b SHALL be 1, 2 or 3 per mode.
  - I bits: symbol[2b-1:b]; Q bits: symbol[b-1:0]; unused upper bits are ignored.
- REQ-021 Each axis SHALL be mapped as:
  - Gray-to-binary giving n in 0..2^b-1;
  - level a = 2n-(2^b-1);
  - output = a * 2^(OUT_W-1-b), two's complement.
- REQ-022 Latency: a symbol accepted in cycle t into an empty FIFO, with out_ready_i high, SHALL appear with data_valid_o=1 in cycle t+2.
- REQ-023 While data_valid_o=1 and out_ready_i=0, I_data, Q_data and data_valid_o SHALL hold.
  - The FIFO pops only when the output register is empty or is being consumed.
- REQ-024 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
  - Push when full is impossible by REQ-017.
- REQ-025 done_flag_o SHALL pulse for exactly one cycle, in the cycle after the last sample of the frame is consumed (data_valid_o && out_ready_i).
  - For a frame with zero symbols, it pulses in the cycle after DRAIN entry.
- REQ-026 data_valid_o SHALL be low in cycles without a fresh or held sample; I/Q values are don't-care when it is low.

Reset
- REQ-027 rst SHALL force, asynchronously:
  - state IDLE, FIFO empty, latched mode 16-QAM;
  - I_data=0, Q_data=0, data_valid_o=0, done_flag_o=0, ready_o=0.
- REQ-028 rst mid-frame SHALL discard all buffered symbols with no done_flag_o.

Configuration
- REQ-029 With macro QAM_DROP_CNT_EN defined, output drop_cnt [15:0] SHALL exist.
  - It counts data_valid_i cycles in RUN with ready_o=0.
  - It saturates at 16'hFFFF, is cleared on start and on rst.
- REQ-030 Without QAM_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent.

Structure
- REQ-031 Package qam_pkg SHALL hold:
  - mode enum (QPSK, QAM16, QAM64);
  - FSM state enum;
  - a bits-per-axis function;
  - the Gray-to-binary function.
- REQ-032 The FIFO SHALL be sub-module qam_sym_fifo, parameterised by width (6) and DEPTH, with full/empty flags.

Verification
- REQ-033 16-QAM, OUT_W=8, symbol 4'b0000 -> I=8'hA0 (-96), Q=8'hA0, data_valid_o two cycles after accept.
- REQ-034 16-QAM, symbol 4'b1011 -> I=8'h60 (+96), Q=8'h20 (+32); QPSK symbol 2'b01 -> I=8'hC0 (-64), Q=8'h40 (+64).
- REQ-035 64-QAM, symbol 6'b100000 -> I=8'h70 (+112), Q=8'h90 (-112).
- REQ-036 out_ready_i held low, 9 symbols offered with DEPTH=8:
  - ready_o falls after the FIFO fills (8 buffered, plus 1 in the output register);
  - further data_valid_i is dropped, and drop_cnt increments when QAM_DROP_CNT_EN is defined;
  - on release, samples emerge in order, unchanged.
- REQ-037 Frame of 3 symbols with done_flag_i on the third -> exactly 3 data_valid_o, then a one-cycle done_flag_o, then state IDLE.
- REQ-038 rst asserted with 4 symbols buffered -> outputs zero immediately, no done_flag_o; a following start/frame maps correctly.
